// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the three-port memory arbiter: requester IDs and the read tag
// that travels alongside each RAM read.
package mem_port_arbiter_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    REQ_PIX = 2'd0,
    REQ_WT  = 2'd1,
    REQ_OUT = 2'd2
  } req_id_e;

  typedef struct packed {
    logic valid;
    logic is_wt;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter with a registered search pointer; the pointer
// moves to the slot after the winner and stays put when nobody is granted.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0]   NUM  = (PW+1)'(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] idx;
  logic [PW:0]   sum;
  logic          any_gnt;

  always_comb begin
    gnt      = '0;
    any_gnt  = 1'b0;
    ptr_next = ptr;
    idx      = '0;
    sum      = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= NUM) sum = sum - NUM;
      idx = sum[PW-1:0];
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        any_gnt  = 1'b1;
        ptr_next = (idx == LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr <= '0;
    else       ptr <= ptr_next;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates pixel/weight reads and output writes onto one RAM port; read returns
// are steered back by a tag that follows the RAM read latency.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_pix_req,
  input  logic [ADDR_W-1:0]   i_pix_addr,
  output logic                o_pix_gnt,
  output logic                o_pix_rvalid,
  output logic [DATA_W-1:0]   o_pix_rdata,
  input  logic                i_wt_req,
  input  logic [ADDR_W-1:0]   i_wt_addr,
  output logic                o_wt_gnt,
  output logic                o_wt_rvalid,
  output logic [DATA_W-1:0]   o_wt_rdata,
  input  logic                i_out_req,
  input  logic [ADDR_W-1:0]   i_out_addr,
  input  logic [DATA_W-1:0]   i_out_wdata,
  input  logic [DATA_W/8-1:0] i_out_wstrb,
  output logic                o_out_gnt,
  output logic                o_rd,
  output logic [ADDR_W-1:0]   o_raddr,
  input  logic [DATA_W-1:0]   i_rdata,
  output logic                o_we,
  output logic [ADDR_W-1:0]   o_waddr,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_wstrb,
  output logic                o_busy
);

  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] gnt_vec;
  logic               cmd_is_wt;
  rd_tag_t            tag_q [RD_LAT];
  rd_tag_t            tag_exit;
  logic               tag_busy;
  logic [DATA_W-1:0]  pix_hold;
  logic [DATA_W-1:0]  wt_hold;

  // Requests are masked during reset so no grant is visible while rstn is low.
  assign req_vec = {i_out_req, i_wt_req, i_pix_req} & {NUM_REQ{rstn}};

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .clk  (clk),
    .rstn (rstn),
    .req  (req_vec),
    .gnt  (gnt_vec)
  );

  assign o_pix_gnt = gnt_vec[REQ_PIX];
  assign o_wt_gnt  = gnt_vec[REQ_WT];
  assign o_out_gnt = gnt_vec[REQ_OUT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_rd      <= 1'b0;
      o_we      <= 1'b0;
      cmd_is_wt <= 1'b0;
      o_raddr   <= '0;
      o_waddr   <= '0;
      o_wdata   <= '0;
      o_wstrb   <= '0;
    end else begin
      o_rd      <= gnt_vec[REQ_PIX] | gnt_vec[REQ_WT];
      o_we      <= gnt_vec[REQ_OUT];
      cmd_is_wt <= gnt_vec[REQ_WT];
      if (gnt_vec[REQ_PIX])     o_raddr <= i_pix_addr;
      else if (gnt_vec[REQ_WT]) o_raddr <= i_wt_addr;
      if (gnt_vec[REQ_OUT]) begin
        o_waddr <= i_out_addr;
        o_wdata <= i_out_wdata;
        o_wstrb <= i_out_wstrb;
      end
    end
  end

  // The last tag stage lines up with the cycle the RAM presents i_rdata.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= rd_tag_t'{valid: o_rd, is_wt: cmd_is_wt};
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    tag_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) tag_busy = tag_busy | tag_q[i].valid;
  end

  assign tag_exit     = tag_q[RD_LAT-1];
  assign o_pix_rvalid = tag_exit.valid & ~tag_exit.is_wt;
  assign o_wt_rvalid  = tag_exit.valid &  tag_exit.is_wt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_hold <= '0;
      wt_hold  <= '0;
    end else begin
      if (o_pix_rvalid) pix_hold <= i_rdata;
      if (o_wt_rvalid)  wt_hold  <= i_rdata;
    end
  end

  assign o_pix_rdata = o_pix_rvalid ? i_rdata : pix_hold;
  assign o_wt_rdata  = o_wt_rvalid  ? i_rdata : wt_hold;
  assign o_busy      = o_rd | o_we | tag_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at RD_LAT=1 (a) and one at
// RD_LAT=3 (b) share all inputs; each gets its own RAM read-data model.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         i_pix_req = 1'b0, i_wt_req = 1'b0, i_out_req = 1'b0;
  logic [27:0]  i_pix_addr = '0, i_wt_addr = '0, i_out_addr = '0;
  logic [127:0] i_out_wdata = '0;
  logic [15:0]  i_out_wstrb = '0;

  logic         pix_gnt_a, wt_gnt_a, out_gnt_a, pix_rv_a, wt_rv_a, rd_a, we_a, busy_a;
  logic [127:0] pix_rdata_a, wt_rdata_a, wdata_a, rdata_a;
  logic [27:0]  raddr_a, waddr_a;
  logic [15:0]  wstrb_a;
  logic         pix_gnt_b, wt_gnt_b, out_gnt_b, pix_rv_b, wt_rv_b, rd_b, we_b, busy_b;
  logic [127:0] pix_rdata_b, wt_rdata_b, wdata_b, rdata_b;
  logic [27:0]  raddr_b, waddr_b;
  logic [15:0]  wstrb_b;

  logic [2:0]   gnt_a, gnt_b;
  logic [28:0]  pipe_a [1];
  logic [28:0]  pipe_b [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign gnt_a = {out_gnt_a, wt_gnt_a, pix_gnt_a};
  assign gnt_b = {out_gnt_b, wt_gnt_b, pix_gnt_b};

  function automatic logic [127:0] pat(input logic [27:0] a);
    return {4{4'hD, a}};
  endfunction

  // RAM models: read data appears RD_LAT cycles after o_rd, garbage otherwise.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_a[0] <= '0;
      pipe_b[0] <= '0; pipe_b[1] <= '0; pipe_b[2] <= '0;
    end else begin
      pipe_a[0] <= {rd_a, raddr_a};
      pipe_b[0] <= {rd_b, raddr_b};
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
    end
  end

  assign rdata_a = pipe_a[0][28] ? pat(pipe_a[0][27:0]) : {4{32'hDEADBEEF}};
  assign rdata_b = pipe_b[2][28] ? pat(pipe_b[2][27:0]) : {4{32'hDEADBEEF}};

  mem_port_arbiter #(.ADDR_W(28), .DATA_W(128), .RD_LAT(1)) dut_a (
    .clk(clk), .rstn(rstn),
    .i_pix_req(i_pix_req), .i_pix_addr(i_pix_addr), .o_pix_gnt(pix_gnt_a),
    .o_pix_rvalid(pix_rv_a), .o_pix_rdata(pix_rdata_a),
    .i_wt_req(i_wt_req), .i_wt_addr(i_wt_addr), .o_wt_gnt(wt_gnt_a),
    .o_wt_rvalid(wt_rv_a), .o_wt_rdata(wt_rdata_a),
    .i_out_req(i_out_req), .i_out_addr(i_out_addr), .i_out_wdata(i_out_wdata),
    .i_out_wstrb(i_out_wstrb), .o_out_gnt(out_gnt_a),
    .o_rd(rd_a), .o_raddr(raddr_a), .i_rdata(rdata_a),
    .o_we(we_a), .o_waddr(waddr_a), .o_wdata(wdata_a), .o_wstrb(wstrb_a),
    .o_busy(busy_a)
  );

  mem_port_arbiter #(.ADDR_W(28), .DATA_W(128), .RD_LAT(3)) dut_b (
    .clk(clk), .rstn(rstn),
    .i_pix_req(i_pix_req), .i_pix_addr(i_pix_addr), .o_pix_gnt(pix_gnt_b),
    .o_pix_rvalid(pix_rv_b), .o_pix_rdata(pix_rdata_b),
    .i_wt_req(i_wt_req), .i_wt_addr(i_wt_addr), .o_wt_gnt(wt_gnt_b),
    .o_wt_rvalid(wt_rv_b), .o_wt_rdata(wt_rdata_b),
    .i_out_req(i_out_req), .i_out_addr(i_out_addr), .i_out_wdata(i_out_wdata),
    .i_out_wstrb(i_out_wstrb), .o_out_gnt(out_gnt_b),
    .o_rd(rd_b), .o_raddr(raddr_b), .i_rdata(rdata_b),
    .o_we(we_b), .o_waddr(waddr_b), .o_wdata(wdata_b), .o_wstrb(wstrb_b),
    .o_busy(busy_b)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_pix_req = 1'b0; i_wt_req = 1'b0; i_out_req = 1'b0;
    i_pix_addr = '0; i_wt_addr = '0; i_out_addr = '0;
    i_out_wdata = '0; i_out_wstrb = '0;
  endtask

  // Leaves the bench just after a rising edge, in the first cycle with rstn high.
  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    next_cycle();
    next_cycle();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    i_pix_req = 1'b1; i_wt_req = 1'b1; i_out_req = 1'b1;
    i_pix_addr = 28'h123; i_out_wdata = {4{32'h55AA55AA}}; i_out_wstrb = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (gnt_a !== 3'b000) begin n_fail++; $display("[TB] FAIL reset gnt_a got=%b exp=000", gnt_a); end
    n_checks++; if (gnt_b !== 3'b000) begin n_fail++; $display("[TB] FAIL reset gnt_b got=%b exp=000", gnt_b); end
    n_checks++; if ({rd_a, we_a, busy_a, pix_rv_a, wt_rv_a} !== 5'b0) begin n_fail++; $display("[TB] FAIL reset ctrl_a got=%b exp=00000", {rd_a, we_a, busy_a, pix_rv_a, wt_rv_a}); end
    n_checks++; if ({rd_b, we_b, busy_b, pix_rv_b, wt_rv_b} !== 5'b0) begin n_fail++; $display("[TB] FAIL reset ctrl_b got=%b exp=00000", {rd_b, we_b, busy_b, pix_rv_b, wt_rv_b}); end
    n_checks++; if ({raddr_a, waddr_a, wstrb_a} !== 72'h0) begin n_fail++; $display("[TB] FAIL reset addr_a got=%h exp=0", {raddr_a, waddr_a, wstrb_a}); end
    n_checks++; if ({wdata_a, pix_rdata_a, wt_rdata_a} !== 384'h0) begin n_fail++; $display("[TB] FAIL reset data_a got=%h exp=0", {wdata_a, pix_rdata_a, wt_rdata_a}); end
    do_reset();
  endtask

  task automatic test_pix_stream();
    logic [127:0] exp_d;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      i_pix_req  = (c < 4);
      i_pix_addr = 28'(16 + c);
      @(negedge clk);
      n_checks++; if (gnt_a !== ((c < 4) ? 3'b001 : 3'b000)) begin n_fail++; $display("[TB] FAIL pix_stream gnt c=%0d got=%b", c, gnt_a); end
      n_checks++; if ({rd_a, we_a} !== {(c >= 1 && c <= 4), 1'b0}) begin n_fail++; $display("[TB] FAIL pix_stream cmd c=%0d got=%b", c, {rd_a, we_a}); end
      if (c >= 1 && c <= 4) begin
        n_checks++; if (raddr_a !== 28'(15 + c)) begin n_fail++; $display("[TB] FAIL pix_stream raddr c=%0d got=%h exp=%h", c, raddr_a, 28'(15 + c)); end
      end
      n_checks++; if ({pix_rv_a, wt_rv_a} !== {(c >= 2 && c <= 5), 1'b0}) begin n_fail++; $display("[TB] FAIL pix_stream rvalid c=%0d got=%b", c, {pix_rv_a, wt_rv_a}); end
      if (c >= 2) begin
        exp_d = pat(28'(16 + ((c > 5) ? 5 : c) - 2));
        n_checks++; if (pix_rdata_a !== exp_d) begin n_fail++; $display("[TB] FAIL pix_stream rdata c=%0d got=%h exp=%h", c, pix_rdata_a, exp_d); end
      end
      n_checks++; if (busy_a !== (c >= 1 && c <= 5)) begin n_fail++; $display("[TB] FAIL pix_stream busy c=%0d got=%b", c, busy_a); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int k, prev;
    do_reset();
    i_pix_addr = 28'h100; i_wt_addr = 28'h200; i_out_addr = 28'h300;
    i_out_wdata = {8{16'h1234}}; i_out_wstrb = 16'hFFFF;
    for (int c = 0; c <= 7; c++) begin
      i_pix_req = (c < 6); i_wt_req = (c < 6); i_out_req = (c < 6);
      @(negedge clk);
      n_checks++; if (gnt_a !== ((c < 6) ? 3'(3'b001 << (c % 3)) : 3'b000)) begin n_fail++; $display("[TB] FAIL round_robin gnt c=%0d got=%b", c, gnt_a); end
      if (c >= 1 && c <= 6) begin
        prev = (c - 1) % 3;
        n_checks++; if ({rd_a, we_a} !== {prev != 2, prev == 2}) begin n_fail++; $display("[TB] FAIL round_robin cmd c=%0d got=%b", c, {rd_a, we_a}); end
        if (prev != 2) begin
          n_checks++; if (raddr_a !== ((prev == 0) ? 28'h100 : 28'h200)) begin n_fail++; $display("[TB] FAIL round_robin raddr c=%0d got=%h", c, raddr_a); end
        end else begin
          n_checks++; if (waddr_a !== 28'h300) begin n_fail++; $display("[TB] FAIL round_robin waddr c=%0d got=%h exp=300", c, waddr_a); end
        end
      end
      k = c - 2;
      n_checks++; if ({pix_rv_a, wt_rv_a} !== {(k >= 0 && k % 3 == 0), (k >= 0 && k % 3 == 1)}) begin n_fail++; $display("[TB] FAIL round_robin rvalid c=%0d got=%b", c, {pix_rv_a, wt_rv_a}); end
      if (wt_rv_a) begin
        n_checks++; if (wt_rdata_a !== pat(28'h200)) begin n_fail++; $display("[TB] FAIL round_robin wt_rdata c=%0d got=%h", c, wt_rdata_a); end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_weight_write();
    do_reset();
    i_wt_addr = 28'h50; i_out_addr = 28'h40;
    i_out_wdata = {16{8'hA5}}; i_out_wstrb = 16'h00FF;
    for (int c = 0; c <= 5; c++) begin
      i_wt_req = (c < 4); i_out_req = (c < 4);
      @(negedge clk);
      n_checks++; if (gnt_a !== ((c < 4) ? ((c % 2 == 0) ? 3'b010 : 3'b100) : 3'b000)) begin n_fail++; $display("[TB] FAIL weight_write gnt c=%0d got=%b", c, gnt_a); end
      if (c >= 1 && c <= 4) begin
        n_checks++; if ({rd_a, we_a} !== ((c % 2 == 1) ? 2'b10 : 2'b01)) begin n_fail++; $display("[TB] FAIL weight_write cmd c=%0d got=%b", c, {rd_a, we_a}); end
        if (c % 2 == 0) begin
          n_checks++; if ({waddr_a, wdata_a, wstrb_a} !== {28'h40, {16{8'hA5}}, 16'h00FF}) begin n_fail++; $display("[TB] FAIL weight_write wcmd c=%0d got=%h %h %h", c, waddr_a, wdata_a, wstrb_a); end
        end
      end
      n_checks++; if ({pix_rv_a, wt_rv_a} !== {1'b0, (c == 2 || c == 4)}) begin n_fail++; $display("[TB] FAIL weight_write rvalid c=%0d got=%b", c, {pix_rv_a, wt_rv_a}); end
      if (c == 2) begin
        n_checks++; if (wt_rdata_a !== pat(28'h50)) begin n_fail++; $display("[TB] FAIL weight_write wt_rdata got=%h", wt_rdata_a); end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_zero_strobe();
    do_reset();
    i_out_wdata = {4{32'h0BADF00D}}; i_out_wstrb = 16'h0000;
    for (int c = 0; c <= 3; c++) begin
      i_out_req = (c < 3); i_out_addr = 28'(60 + c);
      @(negedge clk);
      n_checks++; if (gnt_a !== ((c < 3) ? 3'b100 : 3'b000)) begin n_fail++; $display("[TB] FAIL zero_strobe gnt c=%0d got=%b", c, gnt_a); end
      if (c >= 1) begin
        n_checks++; if ({rd_a, we_a, wstrb_a, waddr_a} !== {2'b01, 16'h0000, 28'(59 + c)}) begin n_fail++; $display("[TB] FAIL zero_strobe wcmd c=%0d got=%b %h %h", c, {rd_a, we_a}, wstrb_a, waddr_a); end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_rd_lat3();
    int k;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      i_pix_req = (c < 4); i_wt_req = (c < 4);
      i_pix_addr = 28'(32 + c); i_wt_addr = 28'(32 + c);
      @(negedge clk);
      n_checks++; if (gnt_b !== ((c < 4) ? ((c % 2 == 0) ? 3'b001 : 3'b010) : 3'b000)) begin n_fail++; $display("[TB] FAIL rd_lat3 gnt c=%0d got=%b", c, gnt_b); end
      k = c - 4;
      n_checks++; if ({pix_rv_b, wt_rv_b} !== {(k >= 0 && k <= 3 && k % 2 == 0), (k >= 0 && k <= 3 && k % 2 == 1)}) begin n_fail++; $display("[TB] FAIL rd_lat3 rvalid c=%0d got=%b", c, {pix_rv_b, wt_rv_b}); end
      if (k >= 0 && k <= 3) begin
        n_checks++; if (((k % 2 == 0) ? pix_rdata_b : wt_rdata_b) !== pat(28'(32 + k))) begin n_fail++; $display("[TB] FAIL rd_lat3 rdata c=%0d got=%h exp=%h", c, (k % 2 == 0) ? pix_rdata_b : wt_rdata_b, pat(28'(32 + k))); end
      end
      n_checks++; if (busy_b !== (c >= 1 && c <= 7)) begin n_fail++; $display("[TB] FAIL rd_lat3 busy c=%0d got=%b", c, busy_b); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      i_pix_req = 1'b1; i_pix_addr = 28'(48 + c);
      next_cycle();
    end
    i_pix_req = 1'b0;
    #1 rstn = 1'b0;
    @(negedge clk);
    n_checks++; if ({busy_a, busy_b, rd_b, gnt_b} !== 6'b0) begin n_fail++; $display("[TB] FAIL reset_inflight during got=%b exp=0", {busy_a, busy_b, rd_b, gnt_b}); end
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      @(negedge clk);
      n_checks++; if ({pix_rv_b, wt_rv_b, busy_b, pix_rv_a, busy_a} !== 5'b0) begin n_fail++; $display("[TB] FAIL reset_inflight after c=%0d got=%b exp=0", c, {pix_rv_b, wt_rv_b, busy_b, pix_rv_a, busy_a}); end
    end
    next_cycle();
    i_pix_req = 1'b1; i_wt_req = 1'b1; i_out_req = 1'b1;
    @(negedge clk);
    n_checks++; if ({gnt_b, gnt_a} !== 6'b001001) begin n_fail++; $display("[TB] FAIL reset_inflight pointer got=%b exp=001001", {gnt_b, gnt_a}); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_drop();
    logic [2:0]  exp_g  [6] = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b000, 3'b000};
    logic [1:0]  exp_c  [6] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00};
    logic [27:0] exp_ra [6] = '{28'h0, 28'h55, 28'h0, 28'h55, 28'h77, 28'h0};
    logic [1:0]  exp_rv [6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10};
    logic        pix_r  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        wt_r   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        out_r  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    i_wt_addr = 28'h55; i_out_addr = 28'h99;
    for (int c = 0; c < 6; c++) begin
      i_pix_req = pix_r[c]; i_wt_req = wt_r[c]; i_out_req = out_r[c];
      i_pix_addr = (c == 1) ? 28'h66 : 28'h77;
      @(negedge clk);
      n_checks++; if (gnt_a !== exp_g[c]) begin n_fail++; $display("[TB] FAIL drop gnt c=%0d got=%b exp=%b", c, gnt_a, exp_g[c]); end
      n_checks++; if ({rd_a, we_a} !== exp_c[c]) begin n_fail++; $display("[TB] FAIL drop cmd c=%0d got=%b exp=%b", c, {rd_a, we_a}, exp_c[c]); end
      if (exp_c[c] == 2'b10) begin
        n_checks++; if (raddr_a !== exp_ra[c]) begin n_fail++; $display("[TB] FAIL drop raddr c=%0d got=%h exp=%h", c, raddr_a, exp_ra[c]); end
      end
      n_checks++; if ({pix_rv_a, wt_rv_a} !== exp_rv[c]) begin n_fail++; $display("[TB] FAIL drop rvalid c=%0d got=%b exp=%b", c, {pix_rv_a, wt_rv_a}, exp_rv[c]); end
      if (c == 5) begin
        n_checks++; if (pix_rdata_a !== pat(28'h77)) begin n_fail++; $display("[TB] FAIL drop pix_rdata got=%h", pix_rdata_a); end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_pix_stream();
    test_round_robin();
    test_weight_write();
    test_zero_strobe();
    test_rd_lat3();
    test_reset_inflight();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters: ADDR_W, 28, word address width; DATA_W, 128, data width (=`AXI_WIDTH); RD_LAT, 1, RAM read latency in cycles (1..4).
REQ-002 clk  in  1  single clock, all logic rising-edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 i_pix_req / o_pix_gnt  in/out  1/1  pixel read request / grant.
REQ-005 i_pix_addr  in  ADDR_W  pixel word address.
REQ-006 o_pix_rvalid / o_pix_rdata  out  1/DATA_W  pixel read return.
REQ-007 i_wt_req, i_wt_addr, o_wt_gnt, o_wt_rvalid, o_wt_rdata: weights read port, same widths as pixel.
REQ-008 i_out_req / o_out_gnt  in/out  1/1  output write request / grant.
REQ-009 i_out_addr / i_out_wdata / i_out_wstrb  in  ADDR_W/DATA_W/DATA_W/8  write address, data, byte strobes.
REQ-010 o_rd / o_raddr  out  1/ADDR_W  RAM read command.
REQ-011 i_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after o_rd.
REQ-012 o_we / o_waddr / o_wdata / o_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  RAM write command.
REQ-013 o_busy  out  1  any read in flight or command registered.

Function
REQ-014 Grant: combinational, at most one gnt per cycle, only to an asserting requester; req without gnt may drop or change address freely.
REQ-015 Round-robin over order pixel(0), weights(1), output(2); search starts at pointer; pointer becomes (granted+1) mod 3 on each grant, unchanged when nothing granted.
REQ-016 Accepted request drives RAM command registers next cycle: read -> o_rd=1, o_raddr; write -> o_we=1, o_waddr/o_wdata/o_wstrb; o_rd and o_we never both 1.
REQ-017 o_wstrb all zero still issues o_we=1 (no suppression).
REQ-018 Read tag (pixel/weights) shifts through RD_LAT-deep pipeline alongside o_rd; at its exit, matching o_*_rvalid=1 for one cycle with o_*_rdata=i_rdata.
REQ-019 Read return latency from gnt cycle: 1+RD_LAT cycles; full throughput, one command per cycle, returns in grant order.
REQ-020 o_*_rdata holds last returned value when rvalid=0.
REQ-021 Single active requester granted every cycle it requests (no bubbles).
REQ-022 o_busy=1 while command register or any tag stage valid.

Reset
REQ-023 On rstn=0: all gnt, rvalid, o_rd, o_we, o_busy=0; addresses, data, strobes, rdata=0; pointer=0 (pixel).
REQ-024 Reset mid-operation discards in-flight tags: no rvalid produced for reads issued before reset.
REQ-025 First grant allowed in first cycle after rstn deasserts.

Structure
REQ-026 Shared package holds requester-ID enum (REQ_PIX=0, REQ_WT=1, REQ_OUT=2), NUM_REQ=3, read-tag typedef.
REQ-027 One sub-module rr_arbiter (parameter N, req vector in, one-hot gnt out, registered pointer); used with N=3.

Verification
REQ-028 Pixel only, addr 0x10..0x13 four consecutive cycles, RD_LAT=1 -> gnt every cycle, o_rd addr 0x10..0x13, pix_rvalid cycles 2..5 with matching data.
REQ-029 All three req continuous from reset -> grant order pix,wt,out,pix,wt,out; o_we every third command.
REQ-030 Weights and output req, output wstrb=16'h00FF, wdata=0xA5.. -> o_we with exactly that strobe; weights rvalid never to pixel port.
REQ-031 RD_LAT=3, interleaved pix/wt reads -> rvalids 4 cycles after each gnt, in grant order, correct port.
REQ-032 rstn pulsed low while 2 reads in flight -> no rvalid afterwards; pointer 0; o_busy=0.
REQ-033 Pixel req dropped before gnt (others granted) -> no pixel command issued, pointer skips correctly.
